// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, flag bit positions and FSM states.
package alu_pkg;

   localparam logic [3:0] OP_XOR = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_ADD = 4'd4;
   localparam logic [3:0] OP_SUB = 4'd5;
   localparam logic [3:0] OP_SRL = 4'd6;
   localparam logic [3:0] OP_SLL = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;
   localparam logic [3:0] OP_SRA = 4'd9;

   localparam int F_N = 3;
   localparam int F_Z = 2;
   localparam int F_C = 1;
   localparam int F_V = 0;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_MUL_RUN = 1'b1
   } state_e;

   function automatic logic op_is_legal(input logic [3:0] op);
      return (op >= OP_XOR) && (op <= OP_SRA);
   endfunction

endpackage

// File: rtl/alu_pipe_booth.sv
// Sequential radix-2 Booth multiplier: one iteration per cycle, W cycles per product.
// done/prod are valid combinationally during the final iteration so the caller can register them.
module booth_seq_mul
   import alu_pkg::*;
#(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] prod
);

   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  m_q, m_d;
   logic [W:0]    acc_q, acc_d;
   logic [W-1:0]  q_q, q_d;
   logic          qm1_q, qm1_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;

   logic [W:0]    sum_s;
   logic [W:0]    acc_sh_s;
   logic [W-1:0]  q_sh_s;

   // Booth step on a W+1 bit accumulator so -(-2^(W-1)) cannot overflow.
   always_comb begin
      case ({q_q[0], qm1_q})
         2'b01:   sum_s = acc_q + {m_q[W-1], m_q};
         2'b10:   sum_s = acc_q - {m_q[W-1], m_q};
         default: sum_s = acc_q;
      endcase
      acc_sh_s = {sum_s[W], sum_s[W:1]};
      q_sh_s   = {sum_s[0], q_q[W-1:1]};
   end

   always_comb begin
      m_d    = m_q;
      acc_d  = acc_q;
      q_d    = q_q;
      qm1_d  = qm1_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (start) begin
         m_d    = a;
         acc_d  = {(W+1){1'b0}};
         q_d    = b;
         qm1_d  = 1'b0;
         cnt_d  = CW'(W);
         busy_d = 1'b1;
      end else if (busy_q) begin
         acc_d  = acc_sh_s;
         q_d    = q_sh_s;
         qm1_d  = q_q[0];
         cnt_d  = cnt_q - CW'(1);
         busy_d = (cnt_q != CW'(1));
      end else begin
         busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_q    <= {W{1'b0}};
         acc_q  <= {(W+1){1'b0}};
         q_q    <= {W{1'b0}};
         qm1_q  <= 1'b0;
         cnt_q  <= {CW{1'b0}};
         busy_q <= 1'b0;
      end else begin
         m_q    <= m_d;
         acc_q  <= acc_d;
         q_q    <= q_d;
         qm1_q  <= qm1_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign busy = busy_q;
   assign done = busy_q && (cnt_q == CW'(1));
   assign prod = {acc_sh_s[W-1:0], q_sh_s};

endmodule

// File: rtl/alu_pipe.sv
// Width-generic valid/ready ALU with a registered output slot, status flags and a
// sequential Booth multiplier; one operation in flight at a time.
module alu_pipe
   import alu_pkg::*;
#(
   parameter  int W   = 32,
   localparam int SHW = $clog2(W)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic [W-1:0] result_hi,
   output logic [3:0]   flags,
   output logic         op_err
);

   state_e         state_q, state_d;
   logic           out_valid_q, out_valid_d;
   logic [W-1:0]   result_q, result_d;
   logic [W-1:0]   result_hi_q, result_hi_d;
   logic [3:0]     flags_q, flags_d;
   logic           op_err_q, op_err_d;

   logic           in_ready_s, accept_s, is_mul_s, start_s;
   logic           mul_busy_s, mul_done_s;
   logic [2*W-1:0] prod_s;
   logic [SHW-1:0] shamt_s;
   logic [W:0]     add_s, sub_s;
   logic [W-1:0]   alu_res_s;
   logic           alu_c_s, alu_v_s, alu_err_s;
   logic           mul_v_s;

   assign in_ready_s = rst_n && (state_q == ST_IDLE) && !mul_busy_s && (!out_valid_q || out_ready);
   assign accept_s   = in_valid && in_ready_s;
   assign is_mul_s   = (op == OP_MUL);
   assign start_s    = accept_s && is_mul_s;
   assign shamt_s    = b[SHW-1:0];
   assign add_s      = {1'b0, a} + {1'b0, b};
   assign sub_s      = {1'b0, a} - {1'b0, b};
   // Product fits in W signed bits only if the top W+1 bits are all equal.
   assign mul_v_s    = !((&prod_s[2*W-1:W-1]) || !(|prod_s[2*W-1:W-1]));

   booth_seq_mul #(.W(W)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_s),
      .a     (a),
      .b     (b),
      .busy  (mul_busy_s),
      .done  (mul_done_s),
      .prod  (prod_s)
   );

   always_comb begin
      alu_res_s = {W{1'b0}};
      alu_c_s   = 1'b0;
      alu_v_s   = 1'b0;
      alu_err_s = !op_is_legal(op);
      case (op)
         OP_XOR: alu_res_s = a ^ b;
         OP_AND: alu_res_s = a & b;
         OP_OR:  alu_res_s = a | b;
         OP_ADD: begin
            alu_res_s = add_s[W-1:0];
            alu_c_s   = add_s[W];
            alu_v_s   = (a[W-1] == b[W-1]) && (add_s[W-1] != a[W-1]);
         end
         OP_SUB: begin
            alu_res_s = sub_s[W-1:0];
            alu_c_s   = !sub_s[W];
            alu_v_s   = (a[W-1] != b[W-1]) && (sub_s[W-1] != a[W-1]);
         end
         OP_SRL:  alu_res_s = a >> shamt_s;
         OP_SLL:  alu_res_s = a << shamt_s;
         OP_SRA:  alu_res_s = $signed(a) >>> shamt_s;
         default: alu_res_s = {W{1'b0}};
      endcase
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      flags_d     = flags_q;
      op_err_d    = op_err_q;

      if (accept_s && !is_mul_s) begin
         out_valid_d = 1'b1;
         result_d    = alu_res_s;
         result_hi_d = {W{1'b0}};
         op_err_d    = alu_err_s;
         flags_d     = 4'b0000;
         if (!alu_err_s) begin
            flags_d[F_N] = alu_res_s[W-1];
            flags_d[F_Z] = (alu_res_s == {W{1'b0}});
            flags_d[F_C] = alu_c_s;
            flags_d[F_V] = alu_v_s;
         end else begin
            flags_d = 4'b0000;
         end
      end else if (mul_done_s) begin
         out_valid_d  = 1'b1;
         result_d     = prod_s[W-1:0];
         result_hi_d  = prod_s[2*W-1:W];
         op_err_d     = 1'b0;
         flags_d      = 4'b0000;
         flags_d[F_N] = prod_s[W-1];
         flags_d[F_Z] = (prod_s == {(2*W){1'b0}});
         flags_d[F_V] = mul_v_s;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end

      case (state_q)
         ST_IDLE:    state_d = start_s ? ST_MUL_RUN : ST_IDLE;
         ST_MUL_RUN: state_d = mul_done_s ? ST_IDLE : ST_MUL_RUN;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= {W{1'b0}};
         result_hi_q <= {W{1'b0}};
         flags_q     <= 4'b0000;
         op_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         flags_q     <= flags_d;
         op_err_q    <= op_err_d;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign flags     = flags_q;
   assign op_err    = op_err_q;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised successor to the team's 32-bit ALU: width-generic, valid/ready handshaked, with a registered output slot and status flags.
- Replaces the free-running combinational/partial-product multiply with a sequential radix-2 Booth multiplier that produces a full 2W-bit signed product.
- Sits between the operand/decode stage and writeback. One operation in flight at a time.

Parameters:
- W, 32, operand and result width in bits; must be even and >= 8.
- SHW, $clog2(W), derived shift-amount width; not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands and op are presented.
- in_ready  out  1  block accepts an operation this cycle.
- op  in  4  operation code (alu_pkg constants).
- a  in  W  signed operand A.
- b  in  W  signed operand B.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  downstream consumes the result this cycle.
- result  out  W  result, or low half of the product.
- result_hi  out  W  high half of the product; 0 for non-MUL ops.
- flags  out  4  {N, Z, C, V} for the held result.
- op_err  out  1  held result came from an illegal opcode.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; out_valid=0, result=0, result_hi=0, flags=0, op_err=0, in_ready=0 during the reset cycle. Reset mid-MUL abandons the operation with no output.
- Accept: a transfer occurs when in_valid && in_ready at a posedge.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This gives full throughput for single-cycle ops when the downstream always drains.
- Opcodes:
  - XOR=1, AND=2, OR=3, ADD=4, SUB=5: operate on W bits.
  - SRL=6: logical right shift by b[SHW-1:0].
  - SLL=7: left shift by b[SHW-1:0].
  - MUL=8: signed W x W -> 2W.
  - SRA=9: arithmetic right shift by b[SHW-1:0].
  - Upper bits of b are ignored for all shifts.
- Illegal opcodes (0, 10-15): result=0, result_hi=0, flags=0, op_err=1, with single-cycle latency.
- Single-cycle ops: result is registered on the accept edge; out_valid=1 the following cycle (latency 1).
- Flags:
  - N = result[W-1].
  - Z = (result==0). For MUL, Z = full 2W product == 0.
  - C = carry out for ADD, not-borrow for SUB (a>=b unsigned); 0 for all other ops.
  - V = signed overflow for ADD/SUB. For MUL, V=1 when the product does not fit in W signed bits. 0 otherwise.
- MUL FSM states: IDLE -> MUL_RUN -> IDLE.
  - On MUL accept: load multiplicand = a, {acc, q, q_-1} = {0, b, 0}, counter = W; go to MUL_RUN. in_ready is 0 throughout MUL_RUN.
  - In MUL_RUN, each cycle: inspect {q[0], q_-1}. 01 adds the multiplicand to acc; 10 subtracts it (W+1-bit acc to hold the sign). Then arithmetic-shift {acc, q, q_-1} right by 1 and decrement the counter.
  - When the counter reaches 1, the final iteration writes result = q (low half) and result_hi = acc (high half), sets out_valid, and returns to IDLE.
  - Latency: W cycles from the accept edge to out_valid.
  - The most-negative x most-negative case (-2^(W-1) squared) must yield the exact 2^(2W-2).
- Output hold: while out_valid && !out_ready, result, result_hi, flags and op_err are stable. A MUL may only be accepted when the output slot will be free, so a completing MUL never overwrites an unconsumed result.
- Simultaneous events: out_ready and a new accept in the same cycle means the old result is consumed and the new one is loaded; out_valid stays 1.
- out_valid drops only on a consume with no new load.
- Inputs are sampled only on the accept edge; changes to a/b/op at any other time have no effect.

Decomposition:
- alu_pkg: opcode localparams (OP_XOR..OP_SRA), flag bit indices (F_N=3, F_Z=2, F_C=1, F_V=0), FSM state enum.
- Sub-module booth_seq_mul, parametrised by W:
  - Ports: clk, rst_n, start, a, b, busy, done, prod[2W-1:0].
  - alu_pipe owns the handshake, the output register and the flags; the combinational ops are inline.

Test Plan (W=32):
- ADD a=0x7FFFFFFF, b=1, out_ready=1 -> next cycle result=0x80000000; N=1, Z=0, C=0, V=1.
- SUB a=5, b=5 -> result=0, Z=1, C=1, V=0. Back-to-back with XOR a=0xF0F0F0F0, b=0xFFFFFFFF -> 0x0F0F0F0F one cycle later. in_ready stays high.
- MUL a=-3, b=7 -> after 32 cycles, {result_hi, result} = 0xFFFFFFFF_FFFFFFEB, V=0. in_ready is 0 for all 32 cycles. MUL a=0x80000000, b=0x80000000 -> {0x40000000, 0x00000000}, V=1.
- SRA a=0x80000000, b=0x0000_0104 (amount 4) -> result 0xF8000000. SRL with the same inputs -> 0x08000000. SLL a=1, b=31 -> 0x80000000.
- Backpressure: ADD 1+2 accepted, out_ready=0 for 5 cycles -> result=3 stable, in_ready=0. Raise out_ready while presenting OR -> result is consumed and the new result loads next cycle.
- rst_n=0 at cycle 10 of a MUL -> next cycle out_valid=0, state=IDLE. No result appears at cycle 32. A fresh op=15 after reset -> result=0, op_err=1.
